// File: rtl/input_ctrl_if.sv
// rtl/input_ctrl_if.sv - keyboard source handshake and KBSR/KBDR register bus
interface input_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ack;
  logic        kbdr_rd;
  logic        kbsr_wr;
  logic [15:0] kbsr_wdata;
  logic [15:0] kbsr;
  logic [15:0] kbdr;
  logic        irq;

  modport master (
    output rx_valid, rx_data, kbdr_rd, kbsr_wr, kbsr_wdata,
    input  rx_ack, kbsr, kbdr, irq
  );

  modport slave (
    input  rx_valid, rx_data, kbdr_rd, kbsr_wr, kbsr_wdata,
    output rx_ack, kbsr, kbdr, irq
  );
endinterface

// File: rtl/input_ctrl.sv
// rtl/input_ctrl.sv - keyboard input controller (KBSR/KBDR), interrupt support via INPUT_IRQ_EN
module input_ctrl (
  input  logic         clk,
  input  logic         reset,
  input_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;
  localparam logic [1:0] FULL     = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       ready;
  logic       ie;
  logic [7:0] char_q;
  logic       ack_q;
  logic       irq_q;
  logic       capture;

  assign capture = (state == IDLE) && bus.rx_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.rx_valid) state_nxt = ACK;
      ACK:      state_nxt = WAIT_LOW;
      // ready may already have been consumed by a read during the handshake
      WAIT_LOW: if (!bus.rx_valid) state_nxt = ready ? FULL : IDLE;
      FULL:     if (!ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ready  <= 1'b0;
      char_q <= 8'h00;
      ack_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= (state == ACK);
      // a capture beats a simultaneous read so the new character is not lost
      if (capture) begin
        char_q <= bus.rx_data;
        ready  <= 1'b1;
      end else if (bus.kbdr_rd) begin
        ready <= 1'b0;
      end
    end
  end

`ifdef INPUT_IRQ_EN
  logic unused_wdata;
  assign unused_wdata = ^{bus.kbsr_wdata[15], bus.kbsr_wdata[13:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      ie    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= ready & ie;
      if (bus.kbsr_wr) ie <= bus.kbsr_wdata[14];
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{bus.kbsr_wr, bus.kbsr_wdata};
  assign ie        = 1'b0;
  assign irq_q     = 1'b0;
`endif

  assign bus.rx_ack = ack_q;
  assign bus.kbsr   = {ready, ie, 14'b0};
  assign bus.kbdr   = {8'h00, char_q};
  assign bus.irq    = irq_q;

endmodule

// File: tb/tb_input_ctrl.sv
// tb/tb_input_ctrl.sv - directed and randomized bench for input_ctrl against a behavioural model
module tb_input_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_ctrl_if bus();
  input_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  int ack_pulses = 0;

  // model: phase 0 free, 1 acknowledging, 2 source still holding, 3 waiting for read
  int         m_phase = 0;
  bit         m_ready = 0;
  bit         m_ie    = 0;
  bit         m_ack   = 0;
  bit         m_irq   = 0;
  logic [7:0] m_char  = 8'h00;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(bit v, logic [7:0] d, bit rd, bit wr, logic [15:0] wd, bit rst);
    bus.rx_valid   = v;
    bus.rx_data    = d;
    bus.kbdr_rd    = rd;
    bus.kbsr_wr    = wr;
    bus.kbsr_wdata = wd;
    reset          = rst;
  endtask

  task automatic step();
    bit cap;
    bit rdy;
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_ready = 0; m_ie = 0; m_ack = 0; m_irq = 0; m_char = 8'h00;
    end else begin
      cap   = (m_phase == 0) && bus.rx_valid;
      rdy   = m_ready;
      m_ack = (m_phase == 1);
`ifdef INPUT_IRQ_EN
      m_irq = m_ready & m_ie;
      if (bus.kbsr_wr) m_ie = bus.kbsr_wdata[14];
`endif
      if (cap) begin
        m_char  = bus.rx_data;
        m_ready = 1;
      end else if (bus.kbdr_rd) begin
        m_ready = 0;
      end
      case (m_phase)
        0: if (cap) m_phase = 1;
        1: m_phase = 2;
        2: if (!bus.rx_valid) m_phase = rdy ? 3 : 0;
        default: if (!rdy) m_phase = 0;
      endcase
    end
    #1;
    check("kbsr", bus.kbsr, {m_ready, m_ie, 14'b0});
    check("kbdr", bus.kbdr, {8'h00, m_char});
    check("rx_ack", bus.rx_ack, m_ack);
    check("irq", bus.irq, m_irq);
    if (bus.rx_ack) ack_pulses++;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 16'h0000, 1);
    step();
    check("reset_kbsr", bus.kbsr, 16'h0000);
    check("reset_kbdr", bus.kbdr, 16'h0000);

    // capture 'A' held three cycles
    ack_pulses = 0;
    drive(1, 8'h41, 0, 0, 16'h0000, 0);
    step();
    check("cap_kbdr", bus.kbdr, 16'h0041);
    check("cap_kbsr", bus.kbsr, 16'h8000);
    steps(2);
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(3);
    check("cap_one_ack", ack_pulses, 1);
    check("full_kbsr", bus.kbsr, 16'h8000);

    // back-pressure while full
    drive(1, 8'h42, 0, 0, 16'h0000, 0);
    steps(3);
    check("bp_no_ack", ack_pulses, 1);
    check("bp_kbdr", bus.kbdr, 16'h0041);
    drive(1, 8'h42, 1, 0, 16'h0000, 0);
    step();
    check("rd_kbsr", bus.kbsr, 16'h0000);
    check("rd_kbdr", bus.kbdr, 16'h0041);
    drive(1, 8'h42, 0, 0, 16'h0000, 0);
    steps(2);
    check("recap_kbdr", bus.kbdr, 16'h0042);
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(3);
    check("recap_ack", ack_pulses, 2);
    drive(0, 8'h00, 1, 0, 16'h0000, 0);
    step();
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(2);

    // read during ACK: handshake ends in IDLE, not FULL
    drive(1, 8'h55, 0, 0, 16'h0000, 0);
    step();
    drive(1, 8'h55, 1, 0, 16'h0000, 0);
    step();
    drive(1, 8'h55, 0, 0, 16'h0000, 0);
    steps(2);
    check("ackrd_kbsr", bus.kbsr, 16'h0000);
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(2);
    drive(1, 8'h66, 0, 0, 16'h0000, 0);
    step();
    check("ackrd_idle_cap", bus.kbdr, 16'h0066);
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(2);
    drive(0, 8'h00, 1, 0, 16'h0000, 0);
    step();
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(2);

    // interrupt enable then capture CR
    drive(0, 8'h00, 0, 1, 16'h4000, 0);
    step();
    drive(1, 8'h0D, 0, 0, 16'h0000, 0);
    step();
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(3);
`ifdef INPUT_IRQ_EN
    check("irq_kbsr", bus.kbsr, 16'hC000);
    check("irq_high", bus.irq, 1);
`else
    check("irq_kbsr", bus.kbsr, 16'h8000);
    check("irq_high", bus.irq, 0);
`endif
    drive(0, 8'h00, 1, 0, 16'h0000, 0);
    step();
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    step();
    check("irq_cleared", bus.irq, 0);
    steps(2);

    // reset in WAIT_LOW with the source still holding
    drive(1, 8'h77, 0, 0, 16'h0000, 0);
    steps(3);
    drive(1, 8'h77, 0, 0, 16'h0000, 1);
    step();
    check("rst_kbsr", bus.kbsr, 16'h0000);
    check("rst_kbdr", bus.kbdr, 16'h0000);
    check("rst_ack", bus.rx_ack, 0);
    check("rst_irq", bus.irq, 0);
    ack_pulses = 0;
    drive(1, 8'h77, 0, 0, 16'h0000, 0);
    steps(4);
    drive(0, 8'h00, 0, 0, 16'h0000, 0);
    steps(3);
    check("rst_recap_ack", ack_pulses, 1);
    check("rst_recap_kbdr", bus.kbdr, 16'h0077);

    // randomized traffic
    begin
      bit v;
      v = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) < 3) v = ~v;
        drive(v, 8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
              16'($urandom), ($urandom_range(0, 96) == 0));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
